// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pixel types and the RGB332 colour expansion helper.
package vga_pkg;

    // 640x480@60 timing, counted in pixel ticks / lines
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_TOTAL  = 525;

    // Counter width; totals must stay below 2**CNT_W
    localparam int unsigned CNT_W = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

    // Per-pixel attributes carried alongside the BRAM read
    typedef struct packed {
        logic active;
        logic in_img;
        logic hsync;
        logic vsync;
    } pix_meta_t;

    // Replicate the top bits so full-scale RGB332 maps to full-scale 4:4:4
    function automatic pixel_t rgb332_to_444(input logic [7:0] d);
        pixel_t p;
        p.r = {d[7:5], d[7]};
        p.g = {d[4:2], d[4]};
        p.b = {d[1:0], d[1:0]};
        return p;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical pixel counters with raw (undelayed) sync, active and wrap flags.
module vga_sync_counter import vga_pkg::*; #(
    parameter int unsigned H_ACT    = H_ACTIVE,
    parameter int unsigned H_FRONT  = H_FP,
    parameter int unsigned H_SYNC_W = H_SYNC,
    parameter int unsigned H_TOT    = H_TOTAL,
    parameter int unsigned V_ACT    = V_ACTIVE,
    parameter int unsigned V_FRONT  = V_FP,
    parameter int unsigned V_SYNC_W = V_SYNC,
    parameter int unsigned V_TOT    = V_TOTAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             frame_wrap
);

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             h_last, v_last;

    // Decode position flags from the current (pre-increment) counters
    always_comb begin
        h_last     = (h_q == CNT_W'(H_TOT - 1));
        v_last     = (v_q == CNT_W'(V_TOT - 1));
        active     = (h_q < CNT_W'(H_ACT)) && (v_q < CNT_W'(V_ACT));
        hsync_raw  = !((h_q >= CNT_W'(H_ACT + H_FRONT)) &&
                       (h_q <  CNT_W'(H_ACT + H_FRONT + H_SYNC_W)));
        vsync_raw  = !((v_q >= CNT_W'(V_ACT + V_FRONT)) &&
                       (v_q <  CNT_W'(V_ACT + V_FRONT + V_SYNC_W)));
        frame_wrap = h_last && v_last;
    end

    // Advance counters on each pixel tick, wrapping at the line/frame totals
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (tick) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + CNT_W'(1);
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
    end

    // Counter state; reset wins over a concurrent tick
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_cnt = h_q;
    assign v_cnt = v_q;

endmodule

// File: rtl/vga_frame_reader.sv
// Scans a scaled, centred RGB332 image out of BRAM onto the VGA pins, with the
// sync signals delayed to match the BRAM read latency.
module vga_frame_reader import vga_pkg::*; #(
    parameter int unsigned IMG_W       = 128,
    parameter int unsigned IMG_H       = 64,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned X_OFF       = 64,
    parameter int unsigned Y_OFF       = 112,
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned RD_LATENCY  = 1,
    parameter logic [7:0]  BORDER      = 8'h00,
    parameter int unsigned H_ACT       = H_ACTIVE,
    parameter int unsigned H_FRONT     = H_FP,
    parameter int unsigned H_SYNC_W    = H_SYNC,
    parameter int unsigned H_TOT       = H_TOTAL,
    parameter int unsigned V_ACT       = V_ACTIVE,
    parameter int unsigned V_FRONT     = V_FP,
    parameter int unsigned V_SYNC_W    = V_SYNC,
    parameter int unsigned V_TOT       = V_TOTAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_tick,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);

    // Stage A plus RD_LATENCY delay stages
    localparam int unsigned DEPTH = RD_LATENCY + 1;

    logic [CNT_W-1:0]  h_cnt, v_cnt;
    logic              active, hsync_raw, vsync_raw, frame_wrap;
    logic [31:0]       h_ext, v_ext, img_x, img_y;
    logic              in_img;
    logic [ADDR_W-1:0] addr_d;

    logic              mem_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              frame_start_q;
    logic [DEPTH-1:0]  vld_q;
    pix_meta_t         meta_q [DEPTH];
    pixel_t            pix_d, pix_q;
    logic              hsync_q, vsync_q;

    vga_sync_counter #(
        .H_ACT    (H_ACT),
        .H_FRONT  (H_FRONT),
        .H_SYNC_W (H_SYNC_W),
        .H_TOT    (H_TOT),
        .V_ACT    (V_ACT),
        .V_FRONT  (V_FRONT),
        .V_SYNC_W (V_SYNC_W),
        .V_TOT    (V_TOT)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .tick       (pix_tick),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .active     (active),
        .hsync_raw  (hsync_raw),
        .vsync_raw  (vsync_raw),
        .frame_wrap (frame_wrap)
    );

    // Image window test and scaled-down image address for the current position
    always_comb begin
        h_ext  = 32'(h_cnt);
        v_ext  = 32'(v_cnt);
        in_img = (h_ext >= X_OFF) && (h_ext < X_OFF + (IMG_W << SCALE_SHIFT)) &&
                 (v_ext >= Y_OFF) && (v_ext < Y_OFF + (IMG_H << SCALE_SHIFT));
        img_x  = (h_ext - X_OFF) >> SCALE_SHIFT;
        img_y  = (v_ext - Y_OFF) >> SCALE_SHIFT;
        addr_d = ADDR_W'(img_y * IMG_W + img_x);
    end

    // Stage A and latency delay line: issue the read and carry pixel attributes alongside
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_q      <= 1'b0;
            mem_addr_q    <= '0;
            frame_start_q <= 1'b0;
            vld_q         <= '0;
            for (int i = 0; i < int'(DEPTH); i++) meta_q[i] <= '0;
        end else begin
            frame_start_q <= pix_tick && frame_wrap;
            vld_q[0]      <= pix_tick;
            if (pix_tick) begin
                // Address holds outside the window so the BRAM input stays quiet
                mem_en_q  <= in_img;
                if (in_img) mem_addr_q <= addr_d;
                meta_q[0] <= '{active: active, in_img: in_img,
                               hsync: hsync_raw, vsync: vsync_raw};
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld_q[i]  <= vld_q[i-1];
                meta_q[i] <= meta_q[i-1];
            end
        end
    end

    // Select image data, border or blank for the pixel emerging from the delay line
    always_comb begin
        pix_d = '0;
        if (meta_q[DEPTH-1].active) begin
            pix_d = meta_q[DEPTH-1].in_img ? rgb332_to_444(mem_data) : rgb332_to_444(BORDER);
        end
    end

    // Stage B: update colour and sync together, holding between pixels
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else if (vld_q[DEPTH-1]) begin
            pix_q   <= pix_d;
            hsync_q <= meta_q[DEPTH-1].hsync;
            vsync_q <= meta_q[DEPTH-1].vsync;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_addr    = mem_addr_q;
    assign frame_start = frame_start_q;
    assign vga_r       = pix_q.r;
    assign vga_g       = pix_q.g;
    assign vga_b       = pix_q.b;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader on a shrunken raster so a full frame fits a short run.
// Raster: 60x26 ticks, active 40x20, hsync low h=44..51, vsync low v=22..23.
// Image 8x4 scaled x4 at (4,2): window h=4..35, v=2..17, addresses 0..31, BORDER=8'h03.
module tb_vga_frame_reader;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned H_TOT  = 60;
    localparam int unsigned V_TOT  = 26;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pix_tick = 1'b0;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data = 8'h00;
    logic [3:0]        vga_r, vga_g, vga_b;
    logic              hsync, vsync, frame_start;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Bench-side raster position (value the counters hold before the next tick)
    int th = 0;
    int tv = 0;
    int pre_h, pre_v;
    int fs_clks = 0;

    logic              cap_en, cap_fs, cap_hs, cap_vs, cap_mid_hs;
    logic [ADDR_W-1:0] cap_addr;
    logic [11:0]       cap_col, cap_mid_col;

    vga_frame_reader #(
        .IMG_W       (8),
        .IMG_H       (4),
        .SCALE_SHIFT (2),
        .X_OFF       (4),
        .Y_OFF       (2),
        .ADDR_W      (ADDR_W),
        .RD_LATENCY  (1),
        .BORDER      (8'h03),
        .H_ACT       (40),
        .H_FRONT     (4),
        .H_SYNC_W    (8),
        .H_TOT       (H_TOT),
        .V_ACT       (20),
        .V_FRONT     (2),
        .V_SYNC_W    (2),
        .V_TOT       (V_TOT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_tick    (pix_tick),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Image byte per address: 8'hE0 ^ (addr << 3), distinct for every address
    function automatic logic [7:0] img_byte(input logic [ADDR_W-1:0] a);
        return 8'hE0 ^ {a, 3'b000};
    endfunction

    // One-cycle-latency BRAM model
    always @(posedge clk) begin
        if (mem_en) mem_data <= img_byte(mem_addr);
    end

    // One pixel tick every 4 clks; captures stage-A outputs 1 clk after the tick edge,
    // outputs 1 clk later (still old) and 2 clks later (this pixel)
    task automatic do_tick();
        @(negedge clk);
        fs_clks += int'(frame_start);
        pix_tick = 1'b1;
        pre_h = th;
        pre_v = tv;
        @(negedge clk);
        pix_tick = 1'b0;
        cap_en   = mem_en;
        cap_addr = mem_addr;
        cap_fs   = frame_start;
        fs_clks += int'(frame_start);
        @(negedge clk);
        cap_mid_col = {vga_r, vga_g, vga_b};
        cap_mid_hs  = hsync;
        fs_clks += int'(frame_start);
        @(negedge clk);
        cap_col = {vga_r, vga_g, vga_b};
        cap_hs  = hsync;
        cap_vs  = vsync;
        fs_clks += int'(frame_start);
        if (th == H_TOT - 1) begin
            th = 0;
            tv = (tv == V_TOT - 1) ? 0 : tv + 1;
        end else begin
            th++;
        end
    endtask

    task automatic goto_pos(input int h, input int v);
        int guard;
        guard = 0;
        while (!(th == h && tv == v)) begin
            do_tick();
            guard++;
            if (guard > int'(H_TOT * V_TOT)) begin
                cmp_cnt++; err_cnt++;
                $display("FAIL goto: position (%0d,%0d) not reached", h, v);
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pix_tick = ~pix_tick;
        end
        @(negedge clk);
        pix_tick = 1'b0;
        cmp_cnt++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            err_cnt++; $display("FAIL reset_colour: got %h want 000", {vga_r, vga_g, vga_b});
        end
        cmp_cnt++;
        if ({hsync, vsync} !== 2'b11) begin
            err_cnt++; $display("FAIL reset_sync: got %b want 11", {hsync, vsync});
        end
        cmp_cnt++;
        if (mem_en !== 1'b0) begin
            err_cnt++; $display("FAIL reset_mem_en: got %b want 0", mem_en);
        end
        cmp_cnt++;
        if (mem_addr !== 5'd0) begin
            err_cnt++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr);
        end
        cmp_cnt++;
        if (frame_start !== 1'b0) begin
            err_cnt++; $display("FAIL reset_frame_start: got %b want 0", frame_start);
        end
        rst = 1'b0;
        th = 0;
        tv = 0;
    endtask

    task automatic test_address();
        // First image pixel: addr 0, byte E0 -> F00; previous pixel (3,2) was border 00F
        goto_pos(4, 2);
        do_tick();
        cmp_cnt++;
        if ({cap_en, cap_addr} !== {1'b1, 5'd0}) begin
            err_cnt++; $display("FAIL first_addr: got en=%b addr=%0d want en=1 addr=0",
                                cap_en, cap_addr);
        end
        cmp_cnt++;
        if (cap_mid_col !== 12'h00F) begin
            err_cnt++; $display("FAIL first_latency: got %h one clk early, want 00F", cap_mid_col);
        end
        cmp_cnt++;
        if (cap_col !== 12'hF00) begin
            err_cnt++; $display("FAIL first_colour: got %h want F00", cap_col);
        end
        // (8,2): addr 1, byte E8 -> F40
        goto_pos(8, 2);
        do_tick();
        cmp_cnt++;
        if ({cap_addr, cap_col} !== {5'd1, 12'hF40}) begin
            err_cnt++; $display("FAIL addr_x_step: got addr=%0d col=%h want addr=1 col=F40",
                                cap_addr, cap_col);
        end
        // (4,6): addr 8, byte A0 -> B00
        goto_pos(4, 6);
        do_tick();
        cmp_cnt++;
        if ({cap_addr, cap_col} !== {5'd8, 12'hB00}) begin
            err_cnt++; $display("FAIL addr_y_step: got addr=%0d col=%h want addr=8 col=B00",
                                cap_addr, cap_col);
        end
        // (35,17): last image pixel, addr 31, byte 18 -> 0D0
        goto_pos(35, 17);
        do_tick();
        cmp_cnt++;
        if ({cap_en, cap_addr, cap_col} !== {1'b1, 5'd31, 12'h0D0}) begin
            err_cnt++; $display("FAIL addr_last: got en=%b addr=%0d col=%h want en=1 addr=31 col=0D0",
                                cap_en, cap_addr, cap_col);
        end
        // (36,17): just outside, enable drops, address holds, border colour
        do_tick();
        cmp_cnt++;
        if ({cap_en, cap_addr, cap_col} !== {1'b0, 5'd31, 12'h00F}) begin
            err_cnt++; $display("FAIL window_exit: got en=%b addr=%0d col=%h want en=0 addr=31 col=00F",
                                cap_en, cap_addr, cap_col);
        end
    endtask

    task automatic test_border_blank();
        goto_pos(1, 1);
        do_tick();
        cmp_cnt++;
        if ({cap_en, cap_col} !== {1'b0, 12'h00F}) begin
            err_cnt++; $display("FAIL border: got en=%b col=%h want en=0 col=00F", cap_en, cap_col);
        end
        goto_pos(45, 1);
        do_tick();
        cmp_cnt++;
        if (cap_col !== 12'h000) begin
            err_cnt++; $display("FAIL blank_h: got %h want 000", cap_col);
        end
        goto_pos(0, 20);
        do_tick();
        cmp_cnt++;
        if (cap_col !== 12'h000) begin
            err_cnt++; $display("FAIL blank_v: got %h want 000", cap_col);
        end
    endtask

    task automatic test_sync();
        int  lows;
        logic exp_hs, prev_hs, exp_vs;
        goto_pos(0, 0);
        lows    = 0;
        prev_hs = 1'b1;
        for (int h = 0; h < int'(H_TOT); h++) begin
            do_tick();
            exp_hs = (pre_h >= 44 && pre_h <= 51) ? 1'b0 : 1'b1;
            if (cap_hs === 1'b0) lows++;
            cmp_cnt++;
            if ({cap_mid_hs, cap_hs, cap_vs} !== {prev_hs, exp_hs, 1'b1}) begin
                err_cnt++; $display("FAIL hsync h=%0d: got mid=%b hs=%b vs=%b want mid=%b hs=%b vs=1",
                                    pre_h, cap_mid_hs, cap_hs, cap_vs, prev_hs, exp_hs);
            end
            prev_hs = exp_hs;
        end
        cmp_cnt++;
        if (lows != 8) begin
            err_cnt++; $display("FAIL hsync_width: got %0d ticks low want 8", lows);
        end
        for (int v = 20; v < int'(V_TOT); v++) begin
            goto_pos(0, v);
            do_tick();
            exp_vs = (v == 22 || v == 23) ? 1'b0 : 1'b1;
            cmp_cnt++;
            if (cap_vs !== exp_vs) begin
                err_cnt++; $display("FAIL vsync v=%0d: got %b want %b", v, cap_vs, exp_vs);
            end
        end
    endtask

    task automatic test_frame_wrap();
        int pulses, fs_h, fs_v;
        goto_pos(0, 0);
        pulses  = 0;
        fs_h    = -1;
        fs_v    = -1;
        fs_clks = 0;
        for (int i = 0; i < int'(H_TOT * V_TOT); i++) begin
            do_tick();
            if (cap_fs === 1'b1) begin
                pulses++;
                fs_h = pre_h;
                fs_v = pre_v;
            end
        end
        cmp_cnt++;
        if (pulses != 1 || fs_clks != 1) begin
            err_cnt++; $display("FAIL frame_start_count: got pulses=%0d high_clks=%0d want 1/1",
                                pulses, fs_clks);
        end
        cmp_cnt++;
        if (fs_h != 59 || fs_v != 25) begin
            err_cnt++; $display("FAIL frame_start_pos: got (%0d,%0d) want (59,25)", fs_h, fs_v);
        end
        // Pixel (0,0) of the new frame is border
        do_tick();
        cmp_cnt++;
        if (cap_col !== 12'h00F) begin
            err_cnt++; $display("FAIL wrap_pixel: got %h want 00F", cap_col);
        end
    endtask

    task automatic test_reset_mid();
        goto_pos(16, 10);
        @(negedge clk);
        pix_tick = 1'b1;
        @(negedge clk);
        pix_tick = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        cmp_cnt++;
        if ({vga_r, vga_g, vga_b, hsync, vsync, mem_en, mem_addr, frame_start} !==
            {12'h000, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0}) begin
            err_cnt++; $display("FAIL mid_reset_outputs: got col=%h hs=%b vs=%b en=%b addr=%0d fs=%b",
                                {vga_r, vga_g, vga_b}, hsync, vsync, mem_en, mem_addr, frame_start);
        end
        rst = 1'b0;
        th  = 0;
        tv  = 0;
        @(negedge clk);
        @(negedge clk);
        cmp_cnt++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            err_cnt++; $display("FAIL mid_reset_stale: got %h want 000", {vga_r, vga_g, vga_b});
        end
        do_tick();
        cmp_cnt++;
        if ({cap_en, cap_addr, cap_col, cap_hs} !== {1'b0, 5'd0, 12'h00F, 1'b1}) begin
            err_cnt++; $display("FAIL mid_reset_first: got en=%b addr=%0d col=%h hs=%b want 0/0/00F/1",
                                cap_en, cap_addr, cap_col, cap_hs);
        end
        goto_pos(4, 2);
        do_tick();
        cmp_cnt++;
        if ({cap_en, cap_addr, cap_col} !== {1'b1, 5'd0, 12'hF00}) begin
            err_cnt++; $display("FAIL mid_reset_img: got en=%b addr=%0d col=%h want 1/0/F00",
                                cap_en, cap_addr, cap_col);
        end
    endtask

    initial begin
        test_reset();
        test_address();
        test_border_blank();
        test_sync();
        test_frame_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
